branch_resolve_unit: RTL

- Closes the prediction loop around the BTB.
- Records each fetch-stage prediction (pc, hit, predicted target) in an in-order tracking FIFO.
- Compares the FIFO head against the execute-stage resolved outcome.
- Issues a registered redirect/flush on mispredict and a write request into the BTB update port (pc, target, write strobe).

---
 rtl/branch_resolve_unit_pkg.sv | 12 +
 rtl/branch_resolve_unit_track_fifo.sv | 65 ++++++
 rtl/branch_resolve_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve unit: the prediction record kept per
// in-flight fetch and the address width it shares with the BTB.
package branch_resolve_unit_pkg;
   localparam int BTB_ADDR_WIDTH = 24;
   localparam int INSTR_BYTES    = 4;

   typedef struct packed {
      logic [BTB_ADDR_WIDTH-1:0] pc;
      logic                      hit;
      logic [BTB_ADDR_WIDTH-1:0] target;
   } pred_entry_t;
endpackage

// File: rtl/branch_resolve_unit_track_fifo.sv
// In-order tracking FIFO for outstanding predictions. Flush beats push/pop;
// a push is accepted at full only when the head is popped in the same cycle.
module bru_track_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [PW:0]      occupancy
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]      cnt_q, cnt_d;
   logic             push_ok, pop_ok;

   assign full      = (cnt_q == (PW+1)'(DEPTH));
   assign empty     = (cnt_q == '0);
   assign occupancy = cnt_q;
   assign rdata     = mem_q[rd_ptr_q];
   assign pop_ok    = pop && !empty;
   assign push_ok   = push && (!full || pop_ok);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end
         if (pop_ok) rd_ptr_d = rd_ptr_q + PW'(1);
         cnt_d = cnt_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Payload needs no reset: entries are only read while counted valid.
   always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/branch_resolve_unit.sv
// Closes the BTB prediction loop: tracks fetch predictions in order, checks
// the head against the execute outcome, and registers redirect/update strobes.
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter  int ADDR_WIDTH  = branch_resolve_unit_pkg::BTB_ADDR_WIDTH,
   parameter  int DEPTH       = 4,
   parameter  int INSTR_BYTES = branch_resolve_unit_pkg::INSTR_BYTES,
   parameter  int CNT_WIDTH   = 16,
   localparam int OW          = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  pred_valid,
   input  logic [ADDR_WIDTH-1:0] pred_pc,
   input  logic                  pred_hit,
   input  logic [ADDR_WIDTH-1:0] pred_target,
   output logic                  pred_ready,
   input  logic                  res_valid,
   input  logic [ADDR_WIDTH-1:0] res_pc,
   input  logic                  res_is_branch,
   input  logic                  res_taken,
   input  logic [ADDR_WIDTH-1:0] res_target,
   output logic                  redirect_valid,
   output logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  upd_valid,
   output logic [ADDR_WIDTH-1:0] upd_pc,
   output logic [ADDR_WIDTH-1:0] upd_target,
   output logic                  sync_err,
   output logic [CNT_WIDTH-1:0]  mispredict_count,
   output logic [OW-1:0]         occupancy
);
   pred_entry_t wr_entry, head;
   logic        full, empty, taken_eff, pc_mis, tgt_diff, mispredict, sync_d, upd_d;
   logic [ADDR_WIDTH-1:0] head_pc, head_target, correct_pc;

   logic                  redirect_valid_q, redirect_valid_d;
   logic [ADDR_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
   logic                  upd_valid_q, upd_valid_d;
   logic [ADDR_WIDTH-1:0] upd_pc_q, upd_pc_d, upd_target_q, upd_target_d;
   logic                  sync_err_q, sync_err_d;
   logic [CNT_WIDTH-1:0]  count_q, count_d;

   always_comb begin
      wr_entry        = '0;
      wr_entry.pc     = BTB_ADDR_WIDTH'(pred_pc);
      wr_entry.hit    = pred_hit;
      wr_entry.target = BTB_ADDR_WIDTH'(pred_target);
   end

   bru_track_fifo #(.WIDTH($bits(pred_entry_t)), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (pred_valid),
      .pop       (res_valid),
      .flush     (mispredict),
      .wdata     (wr_entry),
      .rdata     (head),
      .full      (full),
      .empty     (empty),
      .occupancy (occupancy)
   );

   assign pred_ready  = !full;
   assign head_pc     = ADDR_WIDTH'(head.pc);
   assign head_target = ADDR_WIDTH'(head.target);
   assign taken_eff   = res_is_branch && res_taken;
   assign correct_pc  = taken_eff ? res_target : res_pc + ADDR_WIDTH'(INSTR_BYTES);
   assign pc_mis      = res_pc != head_pc;
   assign tgt_diff    = head_target != res_target;

   // An empty FIFO or a PC mismatch means the tracking is out of sync with
   // execute; treat it as a mispredict so the front end restarts cleanly.
   assign sync_d     = res_valid && (empty || pc_mis);
   assign mispredict = res_valid && (empty || pc_mis || (head.hit != taken_eff) ||
                                     (head.hit && taken_eff && tgt_diff));
   assign upd_d      = res_valid && !empty && taken_eff && (!head.hit || tgt_diff);

   always_comb begin
      redirect_valid_d = mispredict;
      redirect_pc_d    = mispredict ? correct_pc : redirect_pc_q;
      upd_valid_d      = upd_d;
      upd_pc_d         = upd_d ? res_pc : upd_pc_q;
      upd_target_d     = upd_d ? res_target : upd_target_q;
      sync_err_d       = sync_d;
      count_d          = (mispredict && count_q != '1) ? count_q + CNT_WIDTH'(1) : count_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         upd_valid_q      <= 1'b0;
         upd_pc_q         <= '0;
         upd_target_q     <= '0;
         sync_err_q       <= 1'b0;
         count_q          <= '0;
      end else begin
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         upd_valid_q      <= upd_valid_d;
         upd_pc_q         <= upd_pc_d;
         upd_target_q     <= upd_target_d;
         sync_err_q       <= sync_err_d;
         count_q          <= count_d;
      end
   end

   assign redirect_valid   = redirect_valid_q;
   assign redirect_pc      = redirect_pc_q;
   assign upd_valid        = upd_valid_q;
   assign upd_pc           = upd_pc_q;
   assign upd_target       = upd_target_q;
   assign sync_err         = sync_err_q;
   assign mispredict_count = count_q;
endmodule
